// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: redirect requests in, fetch PC handshake and fault status out.
// PC_TRAP_EN adds the trap/mret redirect signals.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            branch;
    logic            b_result;
    logic            jal;
    logic            jalr;
    logic [XLEN-1:0] branch_address;
    logic [XLEN-1:0] jal_address;
    logic [XLEN-1:0] jalr_address;
    logic            pc_ready;
    logic [XLEN-1:0] pc_out;
    logic            pc_valid;
    logic            flush;
    logic            misalign_err;
    logic [XLEN-1:0] misalign_addr;
    logic [1:0]      state_dbg;
`ifdef PC_TRAP_EN
    logic            trap_take;
    logic [XLEN-1:0] trap_vector;
    logic            mret;
    logic [XLEN-1:0] epc;

    modport master (
        input  branch, b_result, jal, jalr,
        input  branch_address, jal_address, jalr_address, pc_ready,
        input  trap_take, trap_vector, mret, epc,
        output pc_out, pc_valid, flush, misalign_err, misalign_addr, state_dbg
    );
    modport slave (
        output branch, b_result, jal, jalr,
        output branch_address, jal_address, jalr_address, pc_ready,
        output trap_take, trap_vector, mret, epc,
        input  pc_out, pc_valid, flush, misalign_err, misalign_addr, state_dbg
    );
`else
    modport master (
        input  branch, b_result, jal, jalr,
        input  branch_address, jal_address, jalr_address, pc_ready,
        output pc_out, pc_valid, flush, misalign_err, misalign_addr, state_dbg
    );
    modport slave (
        output branch, b_result, jal, jalr,
        output branch_address, jal_address, jalr_address, pc_ready,
        input  pc_out, pc_valid, flush, misalign_err, misalign_addr, state_dbg
    );
`endif
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/FAULT FSM, sequential advance on handshake, prioritised redirects.
// Optional trap/mret redirect support is enabled by defining PC_TRAP_EN.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4
) (
    input logic    clk,
    input logic    rst,
    pc_gen_if.master bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN);

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] err_addr_q;
    logic            valid_q;
    logic            flush_q;
    logic            err_q;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            target_misaligned;

    // Handshake: pc_out is a fetch request while pc_valid is high; it is consumed on a cycle
    // where pc_valid and pc_ready are both high. A redirect replaces pc_out whether or not the
    // current request was consumed, and the dropped request is covered by the flush pulse.
    assign redirect = (bus.branch & bus.b_result) | bus.jal | bus.jalr;

    always_comb begin
        target = bus.jalr_address;
        if (bus.branch && bus.b_result) begin
            target = bus.branch_address;
        end else if (bus.jal) begin
            target = bus.jal_address;
        end
    end

    generate
        if (IALIGN == 2) begin : g_align2
            assign target_misaligned = target[0];
        end else begin : g_align4
            assign target_misaligned = |target[1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                BOOT: begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
`ifdef PC_TRAP_EN
                    if (bus.trap_take) begin
                        pc_q    <= bus.trap_vector;
                        flush_q <= 1'b1;
                        err_q   <= 1'b0;
                    end else if (bus.mret) begin
                        pc_q    <= bus.epc;
                        flush_q <= 1'b1;
                    end else
`endif
                    if (redirect) begin
                        if (target_misaligned) begin
                            state      <= FAULT;
                            valid_q    <= 1'b0;
                            err_q      <= 1'b1;
                            err_addr_q <= target;
                        end else begin
                            pc_q    <= target;
                            flush_q <= 1'b1;
                        end
                    end else if (valid_q && bus.pc_ready) begin
                        pc_q <= pc_q + STEP;
                    end
                end
                FAULT: begin
`ifdef PC_TRAP_EN
                    // misalign_addr is kept so the trap handler can read it as mtval.
                    if (bus.trap_take) begin
                        state   <= RUN;
                        pc_q    <= bus.trap_vector;
                        valid_q <= 1'b1;
                        flush_q <= 1'b1;
                        err_q   <= 1'b0;
                    end
`endif
                end
                default: begin
                    state   <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.pc_valid      = valid_q;
    assign bus.flush         = flush_q;
    assign bus.misalign_err  = err_q;
    assign bus.misalign_addr = err_addr_q;
    assign bus.state_dbg     = state;
endmodule
